// File: rtl/sync_tx_launcher.sv
// -----------------------------------------------------------------------------
// sync_tx_launcher
//
// Purpose:
//   clk_a-domain launcher that sits directly in front of the clk_a -> clk_b
//   data synchronizer. Words arrive over a valid/ready handshake and are
//   buffered in a small FIFO. Each word is presented on data_out together with
//   a wide data_en level (HOLD_CYC cycles), followed by a quiet gap of at least
//   GAP_CYC cycles. The two-flop enable path in clk_b therefore samples every
//   word exactly once, and always after its data has settled.
//
// Parameters:
//   DW         data width (matches the synchronizer data width)
//   FIFO_DEPTH input buffer entries, power of 2, >= 2
//   HOLD_CYC   clk_a cycles data_en stays high per word, >= 1
//   GAP_CYC    minimum clk_a cycles data_en stays low between words, >= 1
//
// Ports:
//   clk_a       launch-domain clock
//   arstn       asynchronous active-low reset, clears all state
//   in_data     word to send
//   in_valid    in_data valid
//   in_ready    FIFO not full; a word is taken on in_valid & in_ready
//   data_out    registered data to synchronizer data_in
//   data_en     registered enable to synchronizer data_en
//   busy        launcher active or FIFO holds words
//   tx_count    (only with SYNC_TX_STATS_EN) wrapping count of launches
//   fifo_level  current FIFO occupancy
//
// Optional feature:
//   Define SYNC_TX_STATS_EN to add the 8-bit tx_count output, which counts
//   launch edges (rising data_en) and wraps 255 -> 0. Without the macro the
//   port and counter do not exist and all other behaviour is identical.
// -----------------------------------------------------------------------------
module sync_tx_launcher #(
  parameter int DW         = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_CYC   = 4,
  parameter int GAP_CYC    = 4
) (
  input  logic                          clk_a,
  input  logic                          arstn,
  input  logic [DW-1:0]                 in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DW-1:0]                 data_out,
  output logic                          data_en,
  output logic                          busy,
`ifdef SYNC_TX_STATS_EN
  output logic [7:0]                    tx_count,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  // Counter only ever holds values up to MAX_CYC-1.
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Pointer advance; FIFO_DEPTH is a power of two so the natural wrap of the
  // PTR_W-bit value is the circular wrap at FIFO_DEPTH.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return ptr + PTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
    return c - CNT_W'(1);
  endfunction

  logic [DW-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic             fifo_empty;
  logic             push;
  logic             launch;
  logic [DW-1:0]    head_data;

  assign fifo_empty = (level == '0);
  assign in_ready   = (level != FULL_LVL);
  assign push       = in_valid && in_ready;
  assign head_data  = mem[rd_ptr];

  // A launch (pop + load) happens from IDLE, or at the last GAP cycle, as
  // soon as a word is waiting. It is the only source of pops, so a pop on an
  // empty FIFO cannot occur.
  assign launch = !fifo_empty &&
                  ((state == IDLE) || ((state == GAP) && (cnt == '0)));

  assign busy       = (state != IDLE) || !fifo_empty;
  assign fifo_level = level;

  // ---- Input FIFO stage -----------------------------------------------------
  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (launch) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, launch})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // ---- Launch / hold / gap stage ---------------------------------------------
  // data_out is only written on a launch edge, so it stays frozen through the
  // whole HOLD and GAP window and keeps its last value while IDLE.
  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      state    <= IDLE;
      cnt      <= '0;
      data_out <= '0;
      data_en  <= 1'b0;
    end else if (launch) begin
      data_out <= head_data;
      data_en  <= 1'b1;
      cnt      <= HOLD_LOAD;
      state    <= HOLD;
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt_dec(cnt);
          end else begin
            data_en <= 1'b0;
            cnt     <= GAP_LOAD;
            state   <= GAP;
          end
        end
        GAP: begin
          // cnt == 0 with a waiting word is handled by the launch branch.
          if (cnt != '0) begin
            cnt <= cnt_dec(cnt);
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          data_en <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

`ifdef SYNC_TX_STATS_EN
  // ---- Launch statistics -----------------------------------------------------
  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      tx_count <= '0;
    end else if (launch) begin
      tx_count <= tx_count + 8'd1;
    end
  end
`endif

endmodule

// File: doc/sync_tx_launcher.md
Name: sync_tx_launcher

Overview:
- clk_a-domain stage directly upstream of the clk_a→clk_b 4-bit data synchronizer.
- Accepts words over a valid/ready handshake and buffers them in a small FIFO.
- Drives the synchronizer's data and enable inputs so that data is stable and the enable is a wide, well-spaced level.
- The two-flop clk_b enable path therefore always sees each word exactly once, with its data settled.

Parameters:
- DW, 4, data width; must match synchronizer data width.
- FIFO_DEPTH, 4, input buffer entries; power of 2, >= 2.
- HOLD_CYC, 4, clk_a cycles data_en stays high per word; >= 1, must cover >= 3 clk_b periods.
- GAP_CYC, 4, minimum clk_a cycles data_en stays low between words; >= 1, must cover >= 3 clk_b periods.

Ports:
- clk_a  input  1  launch-domain clock.
- arstn  input  1  reset, asynchronous, active-low; clears everything.
- in_data  input  DW  word to send.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO not full; a word is accepted when in_valid & in_ready at a clk_a edge.
- data_out  output  DW  to synchronizer data_in; registered.
- data_en  output  1  to synchronizer data_en; registered.
- busy  output  1  high when FSM is not IDLE or FIFO is non-empty.
- fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: data_out=0, data_en=0, FIFO empty, fifo_level=0, in_ready=1, busy=0, FSM=IDLE, counter=0.
- Reset is asynchronous: asserting arstn mid-word drops data_en on assertion and discards FIFO contents. First word after release behaves as from a cold start.
- FIFO:
  - Registered storage with circular read/write pointers that wrap at FIFO_DEPTH.
  - in_ready = (fifo_level != FIFO_DEPTH), combinational from registered level.
  - Same-edge push and pop: level unchanged; pop returns the oldest word. No push can occur when full.
  - Pop when empty never happens.
- FSM states IDLE, HOLD, GAP; cnt is a down-counter.
- IDLE:
  - On an edge with FIFO non-empty: pop; data_out<=head word; data_en<=1; cnt<=HOLD_CYC-1; go HOLD.
  - Otherwise hold all outputs; data_out keeps its last value.
- HOLD:
  - cnt!=0: decrement.
  - cnt==0: data_en<=0; cnt<=GAP_CYC-1; go GAP.
  - data_out frozen.
- GAP:
  - cnt!=0: decrement.
  - cnt==0 and FIFO non-empty: behave as the IDLE launch (pop, load, data_en<=1, go HOLD).
  - cnt==0 and FIFO empty: go IDLE.
  - data_out frozen throughout.
- Timing:
  - data_out changes only on the edge where data_en rises.
  - data_en is high for exactly HOLD_CYC cycles and low for at least GAP_CYC cycles between words.
  - Word accepted at edge T into an empty, idle block: data_en rises at edge T+1.
  - Back-to-back launch period is HOLD_CYC+GAP_CYC cycles.
- A word pushed during HOLD/GAP waits in the FIFO. Ordering is strictly FIFO; no word is dropped or duplicated.

Optional Feature:
- Macro SYNC_TX_STATS_EN.
- Defined: adds output tx_count [7:0], reset 0, incremented on each launch edge (data_en rise), wrapping 255→0.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Single word: reset, push 4'hA at edge T → data_en high edges T+1..T+4, data_out=4'hA from T+1, data_en low from T+5, busy drops once GAP ends (T+9).
- Burst: push 4'h1,4'h2,4'h3,4'h4,4'h5 on consecutive cycles → in_ready low when level=4; launches at 8-cycle spacing with data_out 1,2,3,4,5 in order; data_out stable through each HOLD+GAP.
- Simultaneous push/pop: level=2, push on the GAP-expiry pop edge → level stays 2, next launch carries the oldest word.
- Reset mid-HOLD: arstn low at cycle 2 of HOLD → data_en=0, data_out=0, fifo_level=0 immediately. After release, push 4'h7 → normal single-word timing.
- Idle hold: after a launch of 4'hC, no further input for 50 cycles → data_out stays 4'hC, data_en stays 0.
- SYNC_TX_STATS_EN: 257 launches → tx_count=1.
